// File: rtl/bcd_seq_converter_if.sv
// Handshake and result bus between the multiplier/display side and bcd_seq_converter.
// master drives start_i/din_i; slave (the converter) drives status and result.
interface bcd_seq_converter_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start_i;
   logic [WIDTH-1:0]      din_i;
   logic                  busy_o;
   logic                  valid_o;
   logic                  sign_o;
   logic [4*DIGITS-1:0]   bcd_o;
   logic                  ovf_o;
   logic [DIGITS-1:0]     blank_o;

   modport master (
      output start_i, din_i,
      input  busy_o, valid_o, sign_o, bcd_o, ovf_o, blank_o
   );

   modport slave (
      input  start_i, din_i,
      output busy_o, valid_o, sign_o, bcd_o, ovf_o, blank_o
   );
endinterface

// File: rtl/bcd_seq_converter.sv
// Signed binary to BCD by double-dabble, one bit per clock; valid_o pulses WIDTH cycles after start,
// start_i is dropped (not queued) while busy_o; define BCD_LEADING_BLANK_EN for leading-zero blank_o.
module bcd_seq_converter #(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 5,
   parameter int DISP_DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_seq_converter_if.slave   bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_sign_lat;
   logic [WIDTH-1:0]    r_mag;
   logic [BW-1:0]       r_scr;
   logic [CW-1:0]       r_cnt;
   logic                r_sign;
   logic                r_ovf;
   logic [BW-1:0]       r_bcd;
   logic [DIGITS-1:0]   r_blank;

   logic [WIDTH-1:0]    w_mag_in;
   logic [BW-1:0]       w_scr_adj;
   logic [BW-1:0]       w_scr_shf;
   logic                w_last;
   logic                w_ovf;
   logic [DIGITS-1:0]   w_blank;

   // Unsigned WIDTH-bit result keeps -2^(WIDTH-1) as 2^(WIDTH-1) without wrapping.
   assign w_mag_in  = bus.din_i[WIDTH-1] ? (~bus.din_i + WIDTH'(1)) : bus.din_i;
   assign w_scr_shf = {w_scr_adj[BW-2:0], r_mag[WIDTH-1]};
   assign w_last    = (r_cnt == CW'(1));
   assign w_ovf     = |w_scr_shf[BW-1:4*DISP_DIGITS];

   always_comb begin
      w_scr_adj = r_scr;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_scr[4*k +: 4] >= 4'd5)
            w_scr_adj[4*k +: 4] = r_scr[4*k +: 4] + 4'd3;
      end
   end

`ifdef BCD_LEADING_BLANK_EN
   logic w_seen;
   always_comb begin
      w_seen  = 1'b0;
      w_blank = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_seen     = w_seen | (|w_scr_shf[4*k +: 4]);
         w_blank[k] = ~w_seen;
      end
   end
`else
   assign w_blank = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start_i) w_state_nxt = CONV;
         CONV:    if (w_last)      w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sign_lat <= 1'b0;
         r_mag      <= '0;
         r_scr      <= '0;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_ovf      <= 1'b0;
         r_bcd      <= '0;
         r_blank    <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start_i) begin
               r_sign_lat <= bus.din_i[WIDTH-1];
               r_mag      <= w_mag_in;
               r_scr      <= '0;
               r_cnt      <= CW'(WIDTH);
            end
            CONV: begin
               r_scr <= w_scr_shf;
               r_mag <= r_mag << 1;
               r_cnt <= r_cnt - CW'(1);
               // Visible result only moves here, so the display never sees partial digits.
               if (w_last) begin
                  r_bcd   <= w_scr_shf;
                  r_sign  <= r_sign_lat;
                  r_ovf   <= w_ovf;
                  r_blank <= w_blank;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o  = (r_state != IDLE);
   assign bus.valid_o = (r_state == DONE);
   assign bus.sign_o  = r_sign;
   assign bus.bcd_o   = r_bcd;
   assign bus.ovf_o   = r_ovf;
   assign bus.blank_o = r_blank;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: expected results queued at accepted starts, checked at valid_o.
module tb_bcd_seq_converter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct {
      logic [15:0] din;
      int          n0;
   } exp_t;
   exp_t q[$];

   logic [19:0] hold_bcd  = '0;
   logic        hold_sign = 1'b0;

   bcd_seq_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

   bcd_seq_converter #(.WIDTH(16), .DIGITS(5), .DISP_DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_abs(input logic [15:0] d);
      int m;
      m = int'($signed(d));
      return (m < 0) ? -m : m;
   endfunction

   function automatic logic [19:0] m_bcd(input logic [15:0] d);
      int m;
      logic [19:0] r;
      m = m_abs(d);
      r = '0;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] m_blank(input logic [15:0] d);
      logic [19:0] b;
      logic [4:0]  r;
      int          msd;
      b   = m_bcd(d);
      msd = 0;
      r   = '0;
      for (int k = 0; k < 5; k++)
         if (b[4*k +: 4] != 4'd0) msd = k;
      for (int k = 0; k < 5; k++)
         r[k] = (k > msd);
`ifdef BCD_LEADING_BLANK_EN
      return r;
`else
      return (r & 5'b00000);
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         hold_bcd  = '0;
         hold_sign = 1'b0;
      end else if (bus.valid_o) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 32'(bus.valid_o), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", 32'(cyc - e.n0), 32'd16);
            chk("bcd",     32'(bus.bcd_o),   32'(m_bcd(e.din)));
            chk("sign",    32'(bus.sign_o),  32'(e.din[15]));
            chk("ovf",     32'(bus.ovf_o),   32'(m_abs(e.din) > 9999));
            chk("blank",   32'(bus.blank_o), 32'(m_blank(e.din)));
            hold_bcd  = m_bcd(e.din);
            hold_sign = e.din[15];
         end
      end else begin
         chk("hold_bcd",  32'(bus.bcd_o),  32'(hold_bcd));
         chk("hold_sign", 32'(bus.sign_o), 32'(hold_sign));
      end
   end

   task automatic do_start(input logic [15:0] v, input bit accept);
      bus.start_i = 1'b1;
      bus.din_i   = v;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.din_i   = $urandom();
      if (accept) q.push_back('{v, cyc});
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid_o) seen = 1'b1;
      end
      if (!seen) chk("timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input logic [15:0] v);
      do_start(v, 1'b1);
      wait_done();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.din_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  32'(bus.busy_o),  32'd0);
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_sign",  32'(bus.sign_o),  32'd0);
      chk("rst_bcd",   32'(bus.bcd_o),   32'd0);
      chk("rst_ovf",   32'(bus.ovf_o),   32'd0);
      chk("rst_blank", 32'(bus.blank_o), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1234 followed immediately by -56: 0x01234 must hold through the second conversion
      do_start(16'd1234, 1'b1);
      chk("busy_conv", 32'(bus.busy_o), 32'd1);
      wait_done();
      chk("busy_done", 32'(bus.busy_o), 32'd1);
      @(posedge clk);
      #1;
      chk("busy_idle", 32'(bus.busy_o), 32'd0);
      run(16'hFFC8);
      run(16'd16384);
      run(16'h8000);

      // start 99, ignored start of 7 mid-flight and in the DONE cycle, then accepted 7
      do_start(16'd99, 1'b1);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      do_start(16'd7, 1'b0);
      wait_done();
      do_start(16'd7, 1'b0);
      do_start(16'd7, 1'b1);
      wait_done();
      @(posedge clk);
      #1;

      // reset mid-conversion of 500
      do_start(16'd500, 1'b0);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
      chk("mid_rst_bcd",  32'(bus.bcd_o),  32'd0);
      chk("mid_rst_sign", 32'(bus.sign_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      run(16'd0);

      for (int i = 0; i < 6; i++)
         run(16'($urandom()));
      run(16'd9999);
      run(16'd10000);
      run(16'h8001);

      repeat (20) @(posedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential signed-binary-to-BCD converter using iterative double-dabble, one shift per clock.
- Sits directly downstream of the Booth multiplier and consumes its 16-bit signed product Y on the multiplier's valid strobe.
- Produces sign, five registered BCD digits, an overflow flag and a blanking mask for the 4-digit 7-segment display controller.
- Replaces the combinational binary-to-BCD path on the result side, so it tolerates wide products without a long combinational chain.

Parameters:
- WIDTH, 16, bit width of signed input operand.
- DIGITS, 5, number of BCD digits produced; must hold the full magnitude 2^(WIDTH-1).
- DISP_DIGITS, 4, digits physically shown; used for the overflow flag.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (low = reset).
- start_i  input  1  one-cycle strobe; din_i is valid in the same cycle. Driven by the multiplier valid.
- din_i  input  WIDTH  two's-complement value to convert.
- busy_o  output  1  high while a conversion is in progress.
- valid_o  output  1  one-cycle pulse when outputs update.
- sign_o  output  1  1 = negative result.
- bcd_o  output  4*DIGITS  BCD digits; digit 0 in bits [3:0].
- ovf_o  output  1  magnitude exceeds 10^DISP_DIGITS - 1.
- blank_o  output  DIGITS  1 = digit is a leading zero to be blanked.

Behaviour:
- Reset (rst low, async):
  - State IDLE; busy_o = 0, valid_o = 0, sign_o = 0, bcd_o = 0, ovf_o = 0, blank_o = 0.
  - All internal shift, BCD and counter registers cleared.
- States: IDLE, CONV, DONE.
- IDLE, start_i = 1 at edge E0:
  - Latch sign = din_i[WIDTH-1].
  - Latch magnitude = two's-complement absolute value as a WIDTH-bit unsigned value. Most-negative input (-2^(WIDTH-1)) yields magnitude 2^(WIDTH-1) with no wrap.
  - Clear the BCD scratch register, load the shift counter with WIDTH, go to CONV.
- CONV, each edge:
  - Every scratch digit >= 5 gets +3 (all digits in parallel).
  - Then shift {scratch, magnitude} left by 1 and decrement the counter.
  - On the edge where the counter reaches 0 (edge E0+WIDTH): register the final digits into bcd_o, sign into sign_o, compute ovf_o and blank_o, go to DONE.
- DONE: valid_o = 1 for exactly this cycle; next edge returns to IDLE.
- Latency: valid_o is high in the cycle following edge E0+WIDTH, i.e. WIDTH cycles after the start edge (16 for default).
- busy_o: 1 in CONV and DONE, 0 in IDLE.
- start_i while busy_o = 1 is ignored; it is not queued. The in-flight conversion completes unchanged.
- start_i in the DONE cycle is also ignored. The earliest accepted restart is the cycle after valid_o.
- Output stability: bcd_o, sign_o, ovf_o and blank_o change only at the DONE-entry edge and otherwise hold their last value, including through subsequent CONV cycles.
- Zero input: sign_o = 0, bcd_o = 0. Negative zero cannot occur.
- ovf_o = 1 iff any digit at index >= DISP_DIGITS is nonzero.
- Reset asserted mid-conversion: immediate return to IDLE with all outputs at reset values; no valid_o pulse.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined:
  - blank_o[k] = 1 for every digit k above the most significant nonzero digit.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Registered together with bcd_o.
- Undefined: blank_o is held 0 at all times; no blanking logic is synthesized.

Test Plan:
- Reset, then start_i with din_i = 1234 → valid_o exactly 16 cycles after the start edge; bcd_o = 0x01234, sign_o = 0, ovf_o = 0, blank_o = 5'b10000 with macro, 5'b00000 without.
- din_i = -56 (0xFFC8) → bcd_o = 0x00056, sign_o = 1, ovf_o = 0, blank_o = 5'b11100 with macro.
- din_i = 16384 (largest 8x8 signed product, -128 x -128) → bcd_o = 0x16384, sign_o = 0, ovf_o = 1; din_i = -32768 → bcd_o = 0x32768, sign_o = 1, ovf_o = 1.
- Start with din_i = 99; pulse start_i with din_i = 7 at cycle 5 → only one valid_o, at cycle 16, with bcd_o = 0x00099. A new start in the cycle after valid_o produces 0x00007 16 cycles later.
- Start with din_i = 500; assert rst at cycle 8 for 2 cycles → outputs zero immediately, no valid_o. After release, din_i = 0 → bcd_o = 0x00000, sign_o = 0, blank_o = 5'b11110 with macro.
- Back-to-back accepted conversions → bcd_o holds the previous result (e.g. 0x01234) throughout the second conversion and changes only at its DONE edge.
